// File: rtl/up_cu_param.sv
// up_cu_param: parametrised control unit for the enhanced 8-bit processor.
// Moore control decode, except PCload in the conditional-jump states, which follows the flags.
module up_cu_param #(
    parameter int OPW         = 3,
    parameter int MEM_WAIT    = 0,
    parameter bit HALT_RESUME = 1'b0
) (
    input  logic           CLOCK,
    input  logic           RESET,
    input  logic [OPW-1:0] IR,
    input  logic           Aeq0,
    input  logic           Apos,
    input  logic           Enter,
    output logic           IRload,
    output logic           JMPmux,
    output logic           PCload,
    output logic           Meminst,
    output logic           MemWr,
    output logic           Aload,
    output logic           Sub,
    output logic           Halt,
    output logic           Outload,
    output logic [1:0]     Asel,
    output logic [4:0]     outState
);

    typedef enum logic [4:0] {
        S_START   = 5'd0,
        S_FETCH   = 5'd1,
        S_DECODE  = 5'd2,
        S_LOAD    = 5'd8,
        S_STORE   = 5'd9,
        S_ADD     = 5'd10,
        S_SUB     = 5'd11,
        S_IN_WAIT = 5'd12,
        S_JZ      = 5'd13,
        S_JPOS    = 5'd14,
        S_HALT    = 5'd15,
        S_IN_LOAD = 5'd16,
        S_OUT     = 5'd17,
        S_JMP     = 5'd18,
        S_JNZ     = 5'd19,
        S_JNEG    = 5'd20,
        S_NOP     = 5'd21
    } state_t;

    generate
        if ((OPW != 3 && OPW != 4) || MEM_WAIT < 0 || MEM_WAIT > 7) begin : g_bad_param
            $error("up_cu_param: OPW must be 3 or 4 and MEM_WAIT 0..7");
        end
    endgenerate

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    // Opcode widened to 4 bits; with OPW=3 the upper half of the map is unreachable.
    logic [3:0] op;
    generate
        if (OPW == 4) begin : g_op4
            assign op = IR;
        end else begin : g_op3
            assign op = {1'b0, IR};
        end
    endgenerate

    state_t     state, state_nx, op_state;
    logic [2:0] wcnt;
    logic       enter_q;
    logic       rise;
    logic       last;

    assign rise     = Enter & ~enter_q;
    assign last     = (wcnt == WAIT_LAST);
    assign outState = state;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state   <= S_START;
            wcnt    <= '0;
            enter_q <= 1'b0;
        end else begin
            state   <= state_nx;
            enter_q <= Enter;
            // Counter restarts on every state entry; memory states leave on the last count.
            if (state_nx != state)
                wcnt <= '0;
            else if (!last)
                wcnt <= wcnt + 3'd1;
        end
    end

    always_comb begin
        op_state = S_HALT;
        case (op)
            4'd0:                op_state = S_LOAD;
            4'd1:                op_state = S_STORE;
            4'd2:                op_state = S_ADD;
            4'd3:                op_state = S_SUB;
            4'd4:                op_state = S_IN_WAIT;
            4'd5:                op_state = S_JZ;
            4'd6:                op_state = S_JPOS;
            4'd8:                op_state = S_OUT;
            4'd9:                op_state = S_JMP;
            4'd10:               op_state = S_JNZ;
            4'd11:               op_state = S_JNEG;
            4'd12, 4'd13, 4'd14: op_state = S_NOP;
            default:             op_state = S_HALT;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_START:  state_nx = S_FETCH;
            S_FETCH:  if (last) state_nx = S_DECODE;
            S_DECODE: state_nx = op_state;
            S_LOAD, S_STORE, S_ADD, S_SUB:
                if (last) state_nx = S_FETCH;
            S_IN_WAIT: if (rise) state_nx = S_IN_LOAD;
            S_HALT:    if (HALT_RESUME && rise) state_nx = S_FETCH;
            default:   state_nx = S_FETCH;
        endcase
    end

    always_comb begin
        IRload  = 1'b0;
        JMPmux  = 1'b0;
        PCload  = 1'b0;
        Meminst = 1'b0;
        MemWr   = 1'b0;
        Aload   = 1'b0;
        Sub     = 1'b0;
        Halt    = 1'b0;
        Outload = 1'b0;
        Asel    = 2'b00;
        case (state)
            S_FETCH: begin
                IRload = last;
                PCload = last;
            end
            S_DECODE: Meminst = 1'b1;
            S_LOAD: begin
                Meminst = 1'b1;
                Asel    = 2'b10;
                Aload   = last;
            end
            S_STORE: begin
                Meminst = 1'b1;
                MemWr   = last;
            end
            S_ADD: begin
                Meminst = 1'b1;
                Aload   = last;
            end
            S_SUB: begin
                Meminst = 1'b1;
                Sub     = 1'b1;
                Aload   = last;
            end
            S_IN_WAIT: Asel = 2'b01;
            S_IN_LOAD: begin
                Asel  = 2'b01;
                Aload = 1'b1;
            end
            S_JZ: begin
                JMPmux = 1'b1;
                PCload = Aeq0;
            end
            S_JPOS: begin
                JMPmux = 1'b1;
                PCload = Apos;
            end
            S_JNZ: begin
                JMPmux = 1'b1;
                PCload = ~Aeq0;
            end
            S_JNEG: begin
                JMPmux = 1'b1;
                PCload = ~Aeq0 & ~Apos;
            end
            S_JMP: begin
                JMPmux = 1'b1;
                PCload = 1'b1;
            end
            S_OUT:  Outload = 1'b1;
            S_HALT: Halt = 1'b1;
            default: ;
        endcase
    end

endmodule
